seq_control_unit: RTL

Parametrised multi-cycle sequencer for the accumulator CPU; the next-generation control FSM. It adds memory ready handshakes with wait states, a bus timeout, illegal-opcode trapping, a resumable halt and a single vectored interrupt. It sits between the instruction register, PC, accumulator/ALU and the instruction/data memories, and drives all of their enables.

---
 rtl/seq_control_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch/decode/execute/writeback
// with memory wait states, bus timeout, illegal-opcode trap, resumable halt and one vectored IRQ.
module seq_control_unit #(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int EN_IRQ  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             is_zero,
  input  logic             mem_ack,
  input  logic             resume,
  input  logic             irq,
  output logic             ins_req,
  output logic             data_req,
  output logic             data_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_vec,
  output logic             acc_load,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal_op,
  output logic             irq_ack
);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED, S_IRQ
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic IRQ_ON = (EN_IRQ != 0);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_opc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  logic             r_illegal;
  logic             w_set_berr;
  logic             w_set_ill;
  logic             w_timeout;
  logic             w_irq_take;
  logic             w_legal;

  assign w_legal    = (opcode <= OPC_W'(7));
  assign w_irq_take = IRQ_ON && irq;
  // The limit cycle itself is the last one allowed to see an ack.
  assign w_timeout  = (TIMEOUT > 0) && !mem_ack && (r_cnt == LIMIT);
  assign bus_err    = r_bus_err;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET;
      r_opc     <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_opc <= opcode[2:0];
      if (w_next != r_state || mem_ack || !(ins_req || data_req))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_set_berr)
        r_bus_err <= 1'b1;
      if (w_set_ill)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_set_berr = 1'b0;
    w_set_ill  = 1'b0;
    ins_req    = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_vec     = 1'b0;
    acc_load   = 1'b0;
    alu_op     = 2'd0;
    halted     = 1'b0;
    irq_ack    = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        ins_req = 1'b1;
        if (mem_ack) begin
          pc_inc = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_set_berr = 1'b1;
          w_next     = S_HALTED;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_set_ill = 1'b1;
          w_next    = S_HALTED;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_opc)
          OP_HLT: w_next = S_HALTED;
          OP_SKZ: begin
            pc_inc = is_zero;
            w_next = w_irq_take ? S_IRQ : S_FETCH;
          end
          OP_JMP: begin
            pc_load = 1'b1;
            w_next  = w_irq_take ? S_IRQ : S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_WB: begin
        data_req = 1'b1;
        data_we  = (r_opc == OP_STO);
        case (r_opc)
          OP_ADD:  alu_op = 2'd1;
          OP_AND:  alu_op = 2'd2;
          OP_XOR:  alu_op = 2'd3;
          default: alu_op = 2'd0;
        endcase
        if (mem_ack) begin
          acc_load = (r_opc != OP_STO);
          w_next   = w_irq_take ? S_IRQ : S_FETCH;
        end else if (w_timeout) begin
          w_set_berr = 1'b1;
          w_next     = S_HALTED;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        // Sticky errors lock the halt; only reset leaves it.
        if (!(r_bus_err || r_illegal)) begin
          if (w_irq_take)
            w_next = S_IRQ;
          else if (resume)
            w_next = S_FETCH;
        end
      end
      S_IRQ: begin
        pc_load = IRQ_ON;
        pc_vec  = IRQ_ON;
        irq_ack = IRQ_ON;
        w_next  = S_FETCH;
      end
      default: w_next = S_RESET;
    endcase
  end

endmodule
